// File: rtl/sdr_dram_refresh_ctrl.sv
// Host-to-SDR-array access sequencer with a periodic per-row refresh scheduler.
// Refresh wins every decision point; all outputs are decoded from next-state values and registered.
module sdr_dram_refresh_ctrl #(
  parameter int unsigned ADDR_WIDTH       = 4,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned REFRESH_INTERVAL = 32,
  parameter int unsigned ACCESS_CYCLES    = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic [DATA_WIDTH-1:0] ReqWData,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspRData,
  output logic                  DramEnable,
  output logic                  DramRead,
  output logic                  DramWrite,
  output logic                  DramRefresh,
  output logic [ADDR_WIDTH-1:0] DramAddress,
  output logic [DATA_WIDTH-1:0] DramDataOut,
  output logic                  DramDataOE,
  input  logic [DATA_WIDTH-1:0] DramDataIn,
  output logic                  RefreshOverrun
);

  localparam int unsigned TIMER_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int unsigned CNT_W   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(REFRESH_INTERVAL - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH, RESP} state_e;

  state_e                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic                  req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  dram_enable_q, dram_enable_d;
  logic                  dram_read_q, dram_read_d;
  logic                  dram_write_q, dram_write_d;
  logic                  dram_refresh_q, dram_refresh_d;
  logic [ADDR_WIDTH-1:0] dram_address_q, dram_address_d;
  logic [DATA_WIDTH-1:0] dram_data_out_q, dram_data_out_d;
  logic                  dram_data_oe_q, dram_data_oe_d;

  logic tick, last_beat, refresh_exit;

  // Next-state, refresh bookkeeping and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rsp_rdata_d = rsp_rdata_q;

    tick         = (timer_q == '0);
    last_beat    = (cnt_q == CNT_LAST);
    refresh_exit = (state_q == REFRESH) && last_beat;
    timer_d      = tick ? TIMER_RELOAD : timer_q - TIMER_W'(1);
    pending_d    = tick | (pending_q & ~refresh_exit);
    overrun_d    = overrun_q | (tick & pending_q & ~refresh_exit);
    row_d        = refresh_exit ? row_q + ADDR_WIDTH'(1) : row_q;

    unique case (state_q)
      IDLE: begin
        if (pending_q || tick) begin
          state_d = REFRESH;
        end else if (ReqValid && req_ready_q) begin
          state_d     = ACCESS;
          req_write_d = ReqWrite;
          req_addr_d  = ReqAddress;
          req_wdata_d = ReqWData;
        end
      end
      ACCESS: begin
        if (last_beat) begin
          state_d = req_write_q ? IDLE : RESP;
          if (!req_write_q) rsp_rdata_d = DramDataIn;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REFRESH: begin
        if (last_beat) state_d = IDLE;
        else           cnt_d   = cnt_q + CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs reflect the state being entered, so they line up with it once registered
    req_ready_d     = (state_d == IDLE) && !pending_d && (timer_d != '0);
    rsp_valid_d     = (state_d == RESP);
    dram_enable_d   = (state_d == ACCESS) || (state_d == REFRESH);
    dram_read_d     = (state_d == ACCESS) && !req_write_d;
    dram_write_d    = (state_d == ACCESS) && req_write_d;
    dram_data_oe_d  = dram_write_d;
    dram_data_out_d = dram_write_d ? req_wdata_d : '0;
    dram_refresh_d  = (state_d == REFRESH);
    dram_address_d  = (state_d == ACCESS)  ? req_addr_d :
                      (state_d == REFRESH) ? row_d : '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q         <= IDLE;
      timer_q         <= TIMER_RELOAD;
      cnt_q           <= '0;
      pending_q       <= 1'b0;
      overrun_q       <= 1'b0;
      row_q           <= '0;
      req_write_q     <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      dram_enable_q   <= 1'b0;
      dram_read_q     <= 1'b0;
      dram_write_q    <= 1'b0;
      dram_refresh_q  <= 1'b0;
      dram_address_q  <= '0;
      dram_data_out_q <= '0;
      dram_data_oe_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      overrun_q       <= overrun_d;
      row_q           <= row_d;
      req_write_q     <= req_write_d;
      req_addr_q      <= req_addr_d;
      req_wdata_q     <= req_wdata_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      dram_enable_q   <= dram_enable_d;
      dram_read_q     <= dram_read_d;
      dram_write_q    <= dram_write_d;
      dram_refresh_q  <= dram_refresh_d;
      dram_address_q  <= dram_address_d;
      dram_data_out_q <= dram_data_out_d;
      dram_data_oe_q  <= dram_data_oe_d;
    end
  end

  assign ReqReady       = req_ready_q;
  assign RspValid       = rsp_valid_q;
  assign RspRData       = rsp_rdata_q;
  assign DramEnable     = dram_enable_q;
  assign DramRead       = dram_read_q;
  assign DramWrite      = dram_write_q;
  assign DramRefresh    = dram_refresh_q;
  assign DramAddress    = dram_address_q;
  assign DramDataOut    = dram_data_out_q;
  assign DramDataOE     = dram_data_oe_q;
  assign RefreshOverrun = overrun_q;

endmodule

// File: tb/tb_sdr_dram_refresh_ctrl.sv
// Directed bench for sdr_dram_refresh_ctrl: host accesses, refresh scheduling, priority, reset abort, overrun.
module tb_sdr_dram_refresh_ctrl;

  logic       Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Default instance (interval 32, 2 access cycles)
  logic       Reset = 1'b1, ReqValid = 1'b0, ReqWrite = 1'b0;
  logic [3:0] ReqAddress = '0;
  logic [7:0] ReqWData = '0;
  logic       ReqReady, RspValid, DramEnable, DramRead, DramWrite, DramRefresh, DramDataOE, RefreshOverrun;
  logic [7:0] RspRData, DramDataOut, DramDataIn;
  logic [3:0] DramAddress;

  // Overrun instance: interval deliberately too short so refreshes cannot keep up
  logic       Reset_b = 1'b1;
  logic       ReqReady_b, RspValid_b, DramEnable_b, DramRead_b, DramWrite_b, DramRefresh_b, DramDataOE_b, RefreshOverrun_b;
  logic [7:0] RspRData_b, DramDataOut_b;
  logic [3:0] DramAddress_b;

  // Tight-interval instance with continuous reads
  logic       Reset_c = 1'b1, ReqValid_c = 1'b0;
  logic       ReqReady_c, RspValid_c, DramEnable_c, DramRead_c, DramWrite_c, DramRefresh_c, DramDataOE_c, RefreshOverrun_c;
  logic [7:0] RspRData_c, DramDataOut_c;
  logic [3:0] DramAddress_c;

  sdr_dram_refresh_ctrl dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddress(ReqAddress), .ReqWData(ReqWData), .RspValid(RspValid), .RspRData(RspRData),
    .DramEnable(DramEnable), .DramRead(DramRead), .DramWrite(DramWrite), .DramRefresh(DramRefresh),
    .DramAddress(DramAddress), .DramDataOut(DramDataOut), .DramDataOE(DramDataOE),
    .DramDataIn(DramDataIn), .RefreshOverrun(RefreshOverrun));

  sdr_dram_refresh_ctrl #(.REFRESH_INTERVAL(2), .ACCESS_CYCLES(2)) dut_b (
    .Clock(Clock), .Reset(Reset_b), .ReqValid(1'b0), .ReqReady(ReqReady_b), .ReqWrite(1'b0),
    .ReqAddress(4'h0), .ReqWData(8'h00), .RspValid(RspValid_b), .RspRData(RspRData_b),
    .DramEnable(DramEnable_b), .DramRead(DramRead_b), .DramWrite(DramWrite_b), .DramRefresh(DramRefresh_b),
    .DramAddress(DramAddress_b), .DramDataOut(DramDataOut_b), .DramDataOE(DramDataOE_b),
    .DramDataIn(8'h00), .RefreshOverrun(RefreshOverrun_b));

  sdr_dram_refresh_ctrl #(.REFRESH_INTERVAL(6), .ACCESS_CYCLES(2)) dut_c (
    .Clock(Clock), .Reset(Reset_c), .ReqValid(ReqValid_c), .ReqReady(ReqReady_c), .ReqWrite(1'b0),
    .ReqAddress(4'h2), .ReqWData(8'h00), .RspValid(RspValid_c), .RspRData(RspRData_c),
    .DramEnable(DramEnable_c), .DramRead(DramRead_c), .DramWrite(DramWrite_c), .DramRefresh(DramRefresh_c),
    .DramAddress(DramAddress_c), .DramDataOut(DramDataOut_c), .DramDataOE(DramDataOE_c),
    .DramDataIn(8'h3C), .RefreshOverrun(RefreshOverrun_c));

  // Array model for the default instance
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
  always @(posedge Clock) if (DramEnable && DramWrite) mem[DramAddress] <= DramDataOut;
  always_comb DramDataIn = mem[DramAddress];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic advance_to(input int n);
    while (cyc < n) step();
  endtask

  // After return the DUT is in cycle 0 (timer at 31)
  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    cyc = 0;
  endtask

  int refresh_cnt, rsp_cnt, excl_err;
  logic prev_ref, ovr_seen;

  initial begin
    // 1: reset state, write then read back
    do_reset();
    check_eq("rst_enable", DramEnable, 0);
    check_eq("rst_ready", ReqReady, 0);
    check_eq("rst_rspvalid", RspValid, 0);
    check_eq("rst_oe", DramDataOE, 0);
    check_eq("rst_overrun", RefreshOverrun, 0);
    check_eq("rst_addr", DramAddress, 0);
    step();
    check_eq("t1_ready", ReqReady, 1);
    ReqValid = 1; ReqWrite = 1; ReqAddress = 4'h3; ReqWData = 8'hA5;
    step();
    ReqValid = 0;
    check_eq("wr_enable", DramEnable, 1);
    check_eq("wr_strobe", DramWrite, 1);
    check_eq("wr_oe", DramDataOE, 1);
    check_eq("wr_addr", DramAddress, 3);
    check_eq("wr_data", DramDataOut, 8'hA5);
    check_eq("wr_read", DramRead, 0);
    check_eq("wr_ready", ReqReady, 0);
    step();
    check_eq("wr_enable2", DramEnable, 1);
    step();
    check_eq("wr_done_enable", DramEnable, 0);
    check_eq("wr_done_oe", DramDataOE, 0);
    check_eq("wr_done_ready", ReqReady, 1);
    ReqValid = 1; ReqWrite = 0; ReqAddress = 4'h3;
    step();
    ReqValid = 0;
    check_eq("rd_strobe", DramRead, 1);
    check_eq("rd_oe", DramDataOE, 0);
    check_eq("rd_addr", DramAddress, 3);
    step();
    check_eq("rd_enable2", DramEnable, 1);
    check_eq("rd_early_rsp", RspValid, 0);
    step();
    check_eq("rd_rspvalid", RspValid, 1);
    check_eq("rd_rdata", RspRData, 8'hA5);
    step();
    check_eq("rd_rsp_pulse", RspValid, 0);

    // 2: idle refresh cadence and row wrap
    do_reset();
    advance_to(31);
    check_eq("ref_not_yet", DramRefresh, 0);
    for (int k = 0; k <= 16; k++) begin
      advance_to(32 + 32 * k);
      check_eq("ref_strobe", DramRefresh, 1);
      check_eq("ref_row", DramAddress, k % 16);
      check_eq("ref_no_read", DramRead, 0);
    end
    step();
    check_eq("ref_second_beat", DramRefresh, 1);
    step();
    check_eq("ref_end", DramRefresh, 0);
    check_eq("ref_overrun", RefreshOverrun, 0);

    // 3: request collides with tick
    do_reset();
    advance_to(31);
    ReqValid = 1; ReqWrite = 0; ReqAddress = 4'h5;
    check_eq("col_ready", ReqReady, 0);
    step();
    check_eq("col_refresh", DramRefresh, 1);
    check_eq("col_no_read", DramRead, 0);
    step();
    step();
    check_eq("col_ready_after", ReqReady, 1);
    step();
    ReqValid = 0;
    check_eq("col_read", DramRead, 1);
    check_eq("col_addr", DramAddress, 5);
    advance_to(37);
    check_eq("col_rspvalid", RspValid, 1);
    check_eq("col_rdata", RspRData, 8'h15);

    // 4: tick during a read
    do_reset();
    advance_to(30);
    check_eq("inf_ready", ReqReady, 1);
    ReqValid = 1; ReqWrite = 0; ReqAddress = 4'h7;
    step();
    ReqValid = 0;
    check_eq("inf_read", DramRead, 1);
    advance_to(33);
    check_eq("inf_rspvalid", RspValid, 1);
    check_eq("inf_rdata", RspRData, 8'h17);
    step();
    check_eq("inf_ready_blocked", ReqReady, 0);
    check_eq("inf_gap_enable", DramEnable, 0);
    step();
    check_eq("inf_refresh", DramRefresh, 1);
    check_eq("inf_row", DramAddress, 0);
    advance_to(37);
    check_eq("inf_overrun", RefreshOverrun, 0);

    // 6: reset during second read beat
    do_reset();
    advance_to(34);
    check_eq("abort_ready", ReqReady, 1);
    ReqValid = 1; ReqWrite = 0; ReqAddress = 4'h2;
    step();
    ReqValid = 0;
    check_eq("abort_read", DramRead, 1);
    step();
    do_reset();
    check_eq("abort_enable", DramEnable, 0);
    check_eq("abort_read_off", DramRead, 0);
    check_eq("abort_refresh", DramRefresh, 0);
    check_eq("abort_rspvalid", RspValid, 0);
    check_eq("abort_addr", DramAddress, 0);
    step();
    check_eq("abort_no_rsp", RspValid, 0);
    advance_to(31);
    check_eq("abort_timer_early", DramRefresh, 0);
    step();
    check_eq("abort_timer_refresh", DramRefresh, 1);
    check_eq("abort_row", DramAddress, 0);

    // 5a: interval 6 with continuous reads keeps up
    ReqValid_c = 1;
    Reset_c = 1;
    step();
    Reset_c = 0;
    refresh_cnt = 0; rsp_cnt = 0; excl_err = 0; prev_ref = 0; ovr_seen = 0;
    for (int i = 0; i < 124; i++) begin
      if (DramRefresh_c && !prev_ref) refresh_cnt++;
      prev_ref = DramRefresh_c;
      if (RspValid_c) rsp_cnt++;
      if ((32'(DramRead_c) + 32'(DramWrite_c) + 32'(DramRefresh_c)) > 1) excl_err++;
      if (RefreshOverrun_c) ovr_seen = 1;
      step();
    end
    ReqValid_c = 0;
    check_eq("tight_refresh_count", refresh_cnt, 20);
    check_eq("tight_overrun", ovr_seen, 0);
    check_eq("tight_exclusive", excl_err, 0);
    check_eq("tight_reads_progress", rsp_cnt >= 10, 1);
    check_eq("tight_rdata", RspRData_c, 8'h3C);

    // 5b: starved refresh sets sticky overrun
    Reset_b = 1;
    step();
    Reset_b = 0;
    cyc = 0;
    advance_to(5);
    check_eq("ovr_before", RefreshOverrun_b, 0);
    step();
    check_eq("ovr_set", RefreshOverrun_b, 1);
    advance_to(20);
    check_eq("ovr_sticky", RefreshOverrun_b, 1);
    Reset_b = 1;
    step();
    Reset_b = 0;
    check_eq("ovr_cleared", RefreshOverrun_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
